// File: rtl/sigma_pkg.sv
// Shared types and mux encodings for the sigma multi-cycle controller.
package sigma_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J
  } ins_type;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_IMM    = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_LUI    = 7'b0110111
  } opcode_e;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR, ST_MEM_RD,
    ST_MEM_WR, ST_ALU_WB, ST_MEM_WB, ST_BRANCH, ST_JAL, ST_TRAP
  } state_e;

  localparam logic [1:0] SRCA_RS1   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;

  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

endpackage

// File: rtl/sigma_alu_dec.sv
// funct3/funct7 to ALU operation decode, shared by register and immediate forms.
module sigma_alu_dec
  import sigma_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_b5,
  input  logic       i_is_r,
  output alu_op_e    o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ADD;
    case (i_funct3)
      3'b000:  o_alu_op = (i_is_r && i_funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  o_alu_op = ALU_SLL;
      3'b010:  o_alu_op = ALU_SLT;
      3'b011:  o_alu_op = ALU_SLTU;
      3'b100:  o_alu_op = ALU_XOR;
      // funct7[5] selects arithmetic shift for both SRA and SRAI
      3'b101:  o_alu_op = i_funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  o_alu_op = ALU_OR;
      3'b111:  o_alu_op = ALU_AND;
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/sigma_ctrl_fsm.sv
// Multi-cycle RV32 subset control FSM with memory wait timeout and sticky trap.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+4
// DECODE    | ALUOut <= oldPC+imm, dispatch on opcode
// EXEC_R    | register-register ALU op
// EXEC_I    | register-immediate ALU op, LUI as 0+U-imm
// MEM_ADDR  | ALUOut <= rs1+imm, check word access
// MEM_RD    | data read at ALUOut
// MEM_WR    | data write at ALUOut, retire
// ALU_WB    | write ALUOut to rd, retire
// MEM_WB    | write memory data to rd, retire
// BRANCH    | compare rs1-rs2, optional redirect, retire
// JAL       | rd <= PC, PC <= ALUOut, retire
// TRAP      | illegal instruction or bus error, held until reset
module sigma_ctrl_fsm
  import sigma_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output alu_op_e     alu_op,
  output ins_type     imm_type,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        instr_done,
  output logic        trap
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LP_TIMEOUT = WAIT_W'(MEM_TIMEOUT);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_wait_hit;
  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic              w_is_r;
  logic              w_br_taken;
  alu_op_e           w_dec_op;
  logic              w_unused;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_is_r     = (r_state == ST_EXEC_R);
  assign w_br_taken = (w_funct3 == F3_BEQ) ? zero : !zero;
  assign w_unused   = ^{instr[31], instr[29:15], instr[11:7]};

  // Count includes the current stalled cycle, so the trap decision and a
  // late mem_ready are seen together and mem_ready takes priority.
  assign w_wait_inc = r_wait + WAIT_W'(1);
  assign w_wait_hit = (w_wait_inc == LP_TIMEOUT);

  sigma_alu_dec u_alu_dec (
    .i_funct3    (w_funct3),
    .i_funct7_b5 (instr[30]),
    .i_is_r      (w_is_r),
    .o_alu_op    (w_dec_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (mem_req && !mem_ready) r_wait <= w_wait_inc;
      else                       r_wait <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    alu_src_a   = SRCA_RS1;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALU_ADD;
    imm_type    = TYPE_I;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    instr_done  = 1'b0;
    trap        = 1'b0;
    // Outputs are gated by rst_n so an in-flight request drops as soon as reset asserts.
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_we       = 1'b1;
            pc_we       = 1'b1;
            w_state_nxt = ST_DECODE;
          end else if (w_wait_hit) begin
            w_state_nxt = ST_TRAP;
          end
        end
        ST_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          case (w_opcode)
            OPC_OP:              w_state_nxt = ST_EXEC_R;
            OPC_IMM, OPC_LUI:    w_state_nxt = ST_EXEC_I;
            OPC_LOAD, OPC_STORE: w_state_nxt = ST_MEM_ADDR;
            OPC_BRANCH: begin
              imm_type    = TYPE_B;
              w_state_nxt = ST_BRANCH;
            end
            OPC_JAL: begin
              imm_type    = TYPE_J;
              w_state_nxt = ST_JAL;
            end
            default:             w_state_nxt = ST_TRAP;
          endcase
        end
        ST_EXEC_R: begin
          alu_op      = w_dec_op;
          w_state_nxt = ST_ALU_WB;
        end
        ST_EXEC_I: begin
          alu_src_b = SRCB_IMM;
          if (w_opcode == OPC_LUI) begin
            alu_src_a = SRCA_ZERO;
            imm_type  = TYPE_U;
          end else begin
            alu_op = w_dec_op;
          end
          w_state_nxt = ST_ALU_WB;
        end
        ST_MEM_ADDR: begin
          alu_src_b = SRCB_IMM;
          if (w_opcode == OPC_STORE) imm_type = TYPE_S;
          if (w_funct3 != F3_WORD)         w_state_nxt = ST_TRAP;
          else if (w_opcode == OPC_STORE)  w_state_nxt = ST_MEM_WR;
          else                             w_state_nxt = ST_MEM_RD;
        end
        ST_MEM_RD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready)       w_state_nxt = ST_MEM_WB;
          else if (w_wait_hit) w_state_nxt = ST_TRAP;
        end
        ST_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) begin
            instr_done  = 1'b1;
            w_state_nxt = ST_FETCH;
          end else if (w_wait_hit) begin
            w_state_nxt = ST_TRAP;
          end
        end
        ST_ALU_WB: begin
          reg_we      = 1'b1;
          instr_done  = 1'b1;
          w_state_nxt = ST_FETCH;
        end
        ST_MEM_WB: begin
          reg_we      = 1'b1;
          wb_sel      = WB_MEM;
          instr_done  = 1'b1;
          w_state_nxt = ST_FETCH;
        end
        ST_BRANCH: begin
          alu_op   = ALU_SUB;
          imm_type = TYPE_B;
          if (w_funct3 == F3_BEQ || w_funct3 == F3_BNE) begin
            pc_we       = w_br_taken;
            pc_src      = 1'b1;
            instr_done  = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_TRAP;
          end
        end
        ST_JAL: begin
          pc_we       = 1'b1;
          pc_src      = 1'b1;
          reg_we      = 1'b1;
          wb_sel      = WB_PC;
          instr_done  = 1'b1;
          w_state_nxt = ST_FETCH;
        end
        ST_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          w_state_nxt = ST_TRAP;
        end
      endcase
    end
  end

endmodule
